cache_port_arbiter: RTL and testbench
=====================================

# cache_port_arbiter

Shares one K-way cache port among N_REQ requesters and sequences each access into the cache's read/write protocol. Performs round-robin arbitration, issues the read or write pulse, and re-issues write pulses until a missed write has been installed by the cache's CLOCK eviction. Returns a per-requester response. Sits between client ports and the cache instance; it is the only driver of the cache's inputs.

## Interface
- ADDR_WIDTH, 8, address width; matches the cache.
- LINE_WIDTH, 32, line width; matches the cache.
- N_REQ, 2, number of requesters; range 2–8.
- MAX_PROBES, 8, number of write pulses before a write is abandoned with an error.

- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  N_REQ  per-requester request.
- req_write  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_WIDTH  packed; requester i occupies slice i.
- req_wdata  in  N_REQ*LINE_WIDTH  packed write data.
- req_ready  out  N_REQ  one-hot accept strobe.
- resp_valid  out  N_REQ  one-hot, one-cycle response strobe.
- resp_hit  out  1  1 = read hit, or write completed.
- resp_err  out  1  1 = write abandoned after MAX_PROBES.
- resp_data  out  LINE_WIDTH  read data; 0 on a miss or a write.
- c_addr  out  ADDR_WIDTH  to cache in_addr.
- c_val  out  LINE_WIDTH  to cache in_val.
- c_read  out  1  to cache read.
- c_write  out  1  to cache write.
- c_hit  in  1  from cache hit.
- c_out_val  in  LINE_WIDTH  from cache out_val.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_CHECK, WR_ISSUE, WR_CHECK, RESP.
- IDLE
  - Round-robin pick among asserted req_valid, starting at pointer rr.
  - Assert req_ready[g] combinationally in the same cycle.
  - Latch addr, wdata, write and g.
  - Set rr to (g+1) mod N_REQ.
  - Go to RD_ISSUE or WR_ISSUE.
  - No valid requests: stay in IDLE, rr unchanged.
- RD_ISSUE: c_read=1 for one cycle; go to RD_CHECK.
- RD_CHECK: c_read=0; sample c_hit and c_out_val; go to RESP.
- WR_ISSUE: c_write=1 for one cycle; increment probe count; go to WR_CHECK.
- WR_CHECK: c_write=0; sample c_hit.
  - c_hit=1: go to RESP with hit=1.
  - Else if probe count == MAX_PROBES: go to RESP with err=1.
  - Else: return to WR_ISSUE.
- RESP
  - Drive resp_valid[g]=1, resp_hit, resp_err and resp_data for exactly one cycle.
  - resp_data = sampled c_out_val on a read hit, else 0.
  - Return to IDLE.
- c_addr and c_val hold the latched request for the whole transaction. c_read and c_write are never asserted together.
- Requesters hold valid, addr and data stable until they see req_ready. A requester must not drop req_valid before it is accepted.
- At most one transaction is in flight; no request is accepted outside IDLE.

## Timing
- Acceptance at cycle 0. c_read or c_write rises at cycle 1.
- Read: resp_valid at cycle 3.
- Write that hits on the first pulse: resp_valid at cycle 3.
- Each extra write pulse adds 2 cycles: resp_valid at cycle 1+2p for p pulses (p ≤ MAX_PROBES).
- Worst-case write: 1+2*MAX_PROBES cycles.
- Next acceptance is possible no earlier than the cycle after RESP.
- Reset values:
  - State IDLE, rr=0, probe count 0.
  - req_ready, resp_valid, resp_hit and resp_err are 0.
  - resp_data, c_addr and c_val are 0.
  - c_read and c_write are 0.
- Reset mid-transaction:
  - The transaction is dropped and no response is issued.
  - c_read and c_write are low from the first cycle after reset.
  - The cache is not reset, and a pending eviction resumes on the next write pulse. This is legal.
- Simultaneous requests from all requesters are served in rr order, so no requester starves. Each waits at most N_REQ-1 transactions.

## Configuration
- CACHE_ARB_STATS_EN defined:
  - Adds outputs stat_hits and stat_misses (16 bits each, saturating at 16'hFFFF).
  - stat_hits increments in RESP when resp_hit=1.
  - stat_misses increments in RESP on a read miss, or when a write needed more than one pulse.
  - Both counters clear on reset.
- CACHE_ARB_STATS_EN undefined: both ports are present but tied to 0, and no counter logic is built.

## Test plan
- Reset, then idle for 10 cycles: all outputs stay 0 and c_read/c_write never assert.
- Requester 0 writes addr 8'h10 = 32'hDEADBEEF into an empty cache, then reads 8'h10 -> write has resp_hit=1; read at cycle 3 gives resp_hit=1, resp_data=32'hDEADBEEF.
- Requester 1 reads unmapped addr 8'h55 -> resp_valid[1] at cycle 3, resp_hit=0, resp_data=0.
- Both requesters assert at the same cycle after reset -> requester 0 is accepted first, then 1. Repeat -> requester 0 is accepted again next (rr wrapped).
- K=2, write 8'h01, 8'h02, 8'h03, all read back -> the third write takes more than 1 pulse, completes with resp_hit=1 and resp_err=0, and exactly one older address now reads miss.
- Assert reset during WR_CHECK -> no resp_valid, c_write=0 the next cycle, and the following read transaction completes normally.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter that shares one cache port among N_REQ requesters and runs the read/write pulse protocol.
// Latency: read or first-pulse write responds 3 cycles after acceptance; each extra write pulse adds 2 cycles.
// Backpressure: one transaction in flight; req_ready is only offered in IDLE. Optional stats under CACHE_ARB_STATS_EN.
module cache_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int N_REQ      = 2,
  parameter int MAX_PROBES = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*LINE_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            resp_valid,
  output logic                        resp_hit,
  output logic                        resp_err,
  output logic [LINE_WIDTH-1:0]       resp_data,
  output logic [ADDR_WIDTH-1:0]       c_addr,
  output logic [LINE_WIDTH-1:0]       c_val,
  output logic                        c_read,
  output logic                        c_write,
  input  logic                        c_hit,
  input  logic [LINE_WIDTH-1:0]       c_out_val,
  output logic [15:0]                 stat_hits,
  output logic [15:0]                 stat_misses
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = $clog2(MAX_PROBES + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CHECK,
    WR_ISSUE,
    WR_CHECK,
    RESP
  } state_t;

  state_t         state;
  logic [GW-1:0]  rr;
  logic [GW-1:0]  cur_g;
  logic [PW-1:0]  probes;
  logic [GW-1:0]  gnt_idx;
  logic           gnt_any;
  int             cand;

  function automatic logic [N_REQ-1:0] onehot(input logic [GW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan from rr upward with wrap; the candidate closest to rr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr;
    cand    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr) + k >= N_REQ) ? (int'(rr) + k - N_REQ) : (int'(rr) + k);
      if (req_valid[GW'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = GW'(cand);
      end
    end
  end

  assign req_ready = (state == IDLE && gnt_any) ? onehot(gnt_idx) : '0;

  // Transaction sequencer: accept, pulse the cache, collect the outcome, respond for one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= '0;
      cur_g      <= '0;
      probes     <= '0;
      resp_valid <= '0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
      c_addr     <= '0;
      c_val      <= '0;
      c_read     <= 1'b0;
      c_write    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur_g  <= gnt_idx;
            c_addr <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            c_val  <= req_wdata[gnt_idx*LINE_WIDTH +: LINE_WIDTH];
            rr     <= (gnt_idx == GW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            probes <= '0;
            if (req_write[gnt_idx]) begin
              c_write <= 1'b1;
              state   <= WR_ISSUE;
            end else begin
              c_read <= 1'b1;
              state  <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: begin
          c_read <= 1'b0;
          state  <= RD_CHECK;
        end
        RD_CHECK: begin
          resp_valid <= onehot(cur_g);
          resp_hit   <= c_hit;
          resp_err   <= 1'b0;
          resp_data  <= c_hit ? c_out_val : '0;
          state      <= RESP;
        end
        WR_ISSUE: begin
          c_write <= 1'b0;
          probes  <= probes + 1'b1;
          state   <= WR_CHECK;
        end
        WR_CHECK: begin
          if (c_hit) begin
            resp_valid <= onehot(cur_g);
            resp_hit   <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            state      <= RESP;
          end else if (probes == PW'(MAX_PROBES)) begin
            resp_valid <= onehot(cur_g);
            resp_hit   <= 1'b0;
            resp_err   <= 1'b1;
            resp_data  <= '0;
            state      <= RESP;
          end else begin
            // Eviction still in progress inside the cache; pulse again.
            c_write <= 1'b1;
            state   <= WR_ISSUE;
          end
        end
        RESP: begin
          resp_valid <= '0;
          resp_hit   <= 1'b0;
          resp_err   <= 1'b0;
          resp_data  <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  logic [15:0] hits_q;
  logic [15:0] misses_q;
  logic        wr_q;
  logic        miss_evt;

  assign miss_evt = (!wr_q && !resp_hit) || (wr_q && probes > PW'(1));

  // Remember the direction of the accepted request for outcome classification.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= 1'b0;
    end else if (state == IDLE && gnt_any) begin
      wr_q <= req_write[gnt_idx];
    end
  end

  // Saturating outcome counters, updated once per transaction in RESP.
  always_ff @(posedge clock) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (state == RESP) begin
      if (resp_hit && hits_q != 16'hFFFF)
        hits_q <= hits_q + 16'd1;
      if (miss_evt && misses_q != 16'hFFFF)
        misses_q <= misses_q + 16'd1;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
`timescale 1ns/1ps
module tb_cache_port_arbiter;
  localparam int AW = 8;
  localparam int LW = 32;
  localparam int NR = 2;
  localparam int MP = 8;
  localparam int K  = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*LW-1:0] req_wdata = '0;
  logic [NR-1:0]  req_ready, resp_valid;
  logic           resp_hit, resp_err;
  logic [LW-1:0]  resp_data;
  logic [AW-1:0]  c_addr;
  logic [LW-1:0]  c_val;
  logic           c_read, c_write;
  logic           c_hit = 1'b0;
  logic [LW-1:0]  c_out_val = '0;
  logic [15:0]    stat_hits, stat_misses;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cache_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .N_REQ(NR), .MAX_PROBES(MP)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_err(resp_err),
    .resp_data(resp_data), .c_addr(c_addr), .c_val(c_val), .c_read(c_read), .c_write(c_write),
    .c_hit(c_hit), .c_out_val(c_out_val), .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Two K-way CLOCK caches: index 0 is the live cache the DUT talks to, index 1 is the reference shadow.
  logic          cv [2][K];
  logic          cr [2][K];
  logic [AW-1:0] ct [2][K];
  logic [LW-1:0] cd [2][K];
  int            chand [2];
  bit            stuck = 0;

  task automatic flush(input int id);
    for (int i = 0; i < K; i++) begin
      cv[id][i] = 0; cr[id][i] = 0; ct[id][i] = '0; cd[id][i] = '0;
    end
    chand[id] = 0;
  endtask

  task automatic cache_op(input int id, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                          output bit hit, output logic [LW-1:0] q);
    int f = -1;
    int fr = -1;
    int hd;
    hit = 0;
    q = '0;
    for (int i = 0; i < K; i++) begin
      if (cv[id][i] && ct[id][i] == a) f = i;
      if (!cv[id][i] && fr < 0) fr = i;
    end
    hd = chand[id];
    if (!wr) begin
      if (f >= 0) begin hit = 1; q = cd[id][f]; cr[id][f] = 1; end
    end else if (stuck) begin
      hit = 0;
    end else if (f >= 0) begin
      cd[id][f] = d; cr[id][f] = 1; hit = 1;
    end else if (fr >= 0) begin
      cv[id][fr] = 1; ct[id][fr] = a; cd[id][fr] = d; cr[id][fr] = 1; hit = 1;
    end else if (cr[id][hd]) begin
      cr[id][hd] = 0; chand[id] = (hd + 1) % K;
    end else begin
      ct[id][hd] = a; cd[id][hd] = d; cr[id][hd] = 1; chand[id] = (hd + 1) % K; hit = 1;
    end
  endtask

  // Live cache: answers a pulse half a cycle later; junk on the data bus whenever it is not a read hit.
  always @(negedge clock) begin : live_cache
    bit h;
    logic [LW-1:0] q;
    if (c_read === 1'b1) begin
      cache_op(0, 0, c_addr, c_val, h, q);
      c_hit = h;
      c_out_val = h ? q : $urandom();
    end else if (c_write === 1'b1) begin
      cache_op(0, 1, c_addr, c_val, h, q);
      c_hit = h;
      c_out_val = $urandom();
    end
  end

  // Transaction-level reference and per-cycle compare.
  bit            m_busy = 0;
  int            m_t, m_rt, m_g, m_p, m_rr = 0, m_nresp = 0;
  bit            m_write, m_hit, m_err;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_data, m_rdata;
  int            e_hits = 0, e_miss = 0;

  always @(negedge clock) begin : model
    logic [NR-1:0] e_rdy, e_rv;
    logic e_rd, e_wr;
    bit h, inc_h, inc_m;
    logic [LW-1:0] q;
    int g;
    if (reset) begin
      m_busy = 0; m_rr = 0; e_hits = 0; e_miss = 0;
      for (int i = 0; i < K; i++) begin
        cv[1][i] = cv[0][i]; cr[1][i] = cr[0][i]; ct[1][i] = ct[0][i]; cd[1][i] = cd[0][i];
      end
      chand[1] = chand[0];
    end else begin
      e_rdy = '0; e_rv = '0; e_rd = 0; e_wr = 0; inc_h = 0; inc_m = 0;
      if (m_busy) begin
        m_t++;
        e_rd = !m_write && m_t == 1;
        e_wr = m_write && (m_t % 2 == 1) && m_t < 2 * m_p;
        chk("c_addr", c_addr, m_addr);
        chk("c_val", c_val, m_data);
        if (m_t == m_rt) begin
          e_rv[m_g] = 1'b1;
          chk("resp_hit", resp_hit, m_hit);
          chk("resp_err", resp_err, m_err);
          chk("resp_data", resp_data, m_rdata);
          inc_h = m_hit;
          inc_m = (!m_write && !m_hit) || (m_write && m_p > 1);
          m_busy = 0;
          m_nresp++;
        end
      end else begin
        g = -1;
        for (int k = NR - 1; k >= 0; k--)
          if (req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        if (g >= 0) begin
          e_rdy[g] = 1'b1;
          m_busy = 1; m_t = 0; m_g = g; m_rr = (g + 1) % NR;
          m_write = req_write[g];
          m_addr = req_addr[g*AW +: AW];
          m_data = req_wdata[g*LW +: LW];
          if (!m_write) begin
            cache_op(1, 0, m_addr, m_data, h, q);
            m_p = 0; m_hit = h; m_err = 0; m_rdata = h ? q : '0; m_rt = 3;
          end else begin
            m_p = 0; h = 0;
            while (!h && m_p < MP) begin
              cache_op(1, 1, m_addr, m_data, h, q);
              m_p++;
            end
            m_hit = h; m_err = !h; m_rdata = '0; m_rt = 1 + 2 * m_p;
          end
        end
      end
      chk("req_ready", req_ready, e_rdy);
      chk("resp_valid", resp_valid, e_rv);
      chk("c_read", c_read, e_rd);
      chk("c_write", c_write, e_wr);
`ifdef CACHE_ARB_STATS_EN
      chk("stat_hits", stat_hits, 16'(e_hits));
      chk("stat_misses", stat_misses, 16'(e_miss));
`else
      chk("stat_hits", stat_hits, 0);
      chk("stat_misses", stat_misses, 0);
`endif
      if (inc_h && e_hits < 65535) e_hits++;
      if (inc_m && e_miss < 65535) e_miss++;
    end
  end

  task automatic do_reset(input int n);
    @(posedge clock); #1 reset = 1;
    repeat (n) @(posedge clock);
    #1 reset = 0;
  endtask

  // Raise a request, hold it until accepted, drop it at the start of the next cycle.
  task automatic send(input int i, input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d);
    int n = 0;
    @(posedge clock); #1;
    req_valid[i] = 1; req_write[i] = w; req_addr[i*AW +: AW] = a; req_wdata[i*LW +: LW] = d;
    do begin @(negedge clock); n++; end while (!req_ready[i] && n < 50);
    if (!req_ready[i]) begin
      checks++; failures++;
      $display("FAIL send_timeout: req %0d never accepted", i);
    end
    @(posedge clock); #1 req_valid[i] = 0;
  endtask

  // Latency counted in cycles from acceptance (cycle 0).
  task automatic wait_resp(input int i, output int lat, output logic h, output logic e,
                           output logic [LW-1:0] dat, output logic [NR-1:0] rv);
    bit done = 0;
    lat = 0;
    while (!done) begin
      @(negedge clock);
      lat++;
      if (resp_valid[i]) done = 1;
      else if (lat > 40) begin
        checks++; failures++;
        $display("FAIL resp_timeout: req %0d got no response", i);
        done = 1;
      end
    end
    h = resp_hit; e = resp_err; dat = resp_data; rv = resp_valid;
  endtask

  task automatic txn(input int i, input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d,
                     output int lat, output logic h, output logic e, output logic [LW-1:0] dat,
                     output logic [NR-1:0] rv);
    send(i, w, a, d);
    wait_resp(i, lat, h, e, dat, rv);
  endtask

  task automatic pair(output int first, output int second);
    int n = 0;
    int order[$];
    logic [NR-1:0] rs;
    @(posedge clock); #1;
    req_write = '0;
    req_addr[0*AW +: AW] = 8'h10;
    req_addr[1*AW +: AW] = 8'h55;
    req_valid = '1;
    while (order.size() < 2 && n < 60) begin
      @(negedge clock); n++; rs = req_ready;
      @(posedge clock); #1;
      for (int i = 0; i < NR; i++)
        if (rs[i]) begin order.push_back(i); req_valid[i] = 0; end
    end
    req_valid = '0;
    first  = (order.size() > 0) ? order[0] : -1;
    second = (order.size() > 1) ? order[1] : -1;
    repeat (6) @(negedge clock);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat, f0, s0, miss_cnt, nrv, n0;
    logic h, e;
    logic [LW-1:0] dat;
    logic [NR-1:0] rv, rs;
    flush(0); flush(1);
    repeat (3) @(posedge clock);
    #1 reset = 0;

    // Quiet after reset.
    repeat (10) begin
      @(negedge clock);
      chk("idle_resp_hit", resp_hit, 0);
      chk("idle_resp_err", resp_err, 0);
      chk("idle_resp_data", resp_data, 0);
      chk("idle_c_addr", c_addr, 0);
      chk("idle_c_val", c_val, 0);
      chk("idle_c_rw", {c_read, c_write}, 0);
    end

    // Write then read back from an empty cache.
    txn(0, 1, 8'h10, 32'hDEADBEEF, lat, h, e, dat, rv);
    chk("wr10_lat", lat, 3); chk("wr10_hit", h, 1); chk("wr10_err", e, 0);
    txn(0, 0, 8'h10, 32'h0, lat, h, e, dat, rv);
    chk("rd10_lat", lat, 3); chk("rd10_hit", h, 1); chk("rd10_data", dat, 32'hDEADBEEF);

    // Unmapped read from requester 1.
    txn(1, 0, 8'h55, 32'h0, lat, h, e, dat, rv);
    chk("rd55_lat", lat, 3); chk("rd55_rv", rv, 2'b10); chk("rd55_hit", h, 0); chk("rd55_data", dat, 0);

    // Simultaneous requests after reset, twice.
    do_reset(2);
    pair(f0, s0);
    chk("arb1_first", f0, 0); chk("arb1_second", s0, 1);
    pair(f0, s0);
    chk("arb2_first", f0, 0); chk("arb2_second", s0, 1);

    // CLOCK eviction on a full 2-way cache.
    @(posedge clock); #1 flush(0); flush(1);
    txn(0, 1, 8'h01, 32'h11111111, lat, h, e, dat, rv);
    chk("wr01_lat", lat, 3);
    txn(0, 1, 8'h02, 32'h22222222, lat, h, e, dat, rv);
    chk("wr02_lat", lat, 3);
    txn(1, 1, 8'h03, 32'h33333333, lat, h, e, dat, rv);
    chk("wr03_lat", lat, 7); chk("wr03_hit", h, 1); chk("wr03_err", e, 0);
    miss_cnt = 0;
    txn(0, 0, 8'h01, 32'h0, lat, h, e, dat, rv); if (!h) miss_cnt++;
    chk("rd01_hit", h, 0);
    txn(0, 0, 8'h02, 32'h0, lat, h, e, dat, rv); if (!h) miss_cnt++;
    chk("rd02_data", dat, 32'h22222222);
    txn(1, 0, 8'h03, 32'h0, lat, h, e, dat, rv); if (!h) miss_cnt++;
    chk("rd03_data", dat, 32'h33333333);
    chk("evict_miss_count", miss_cnt, 1);

    // Write that never installs is abandoned after MP pulses.
    stuck = 1;
    txn(0, 1, 8'h20, 32'hCAFEF00D, lat, h, e, dat, rv);
    chk("abandon_lat", lat, 1 + 2 * MP); chk("abandon_err", e, 1); chk("abandon_hit", h, 0);

    // Reset while the write sits in WR_CHECK.
    send(1, 1, 8'h21, 32'h12345678);
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    chk("rst_c_write", c_write, 0);
    chk("rst_resp_valid", resp_valid, 0);
    nrv = 0;
    repeat (20) begin @(negedge clock); if (resp_valid != 0) nrv++; end
    chk("rst_no_resp", nrv, 0);
    stuck = 0;
    txn(1, 0, 8'h02, 32'h0, lat, h, e, dat, rv);
    chk("post_rst_lat", lat, 3); chk("post_rst_hit", h, 1); chk("post_rst_data", dat, 32'h22222222);

    // Random traffic against the reference.
    n0 = m_nresp;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock); rs = req_ready;
      @(posedge clock); #1;
      for (int i = 0; i < NR; i++) begin
        if (rs[i]) req_valid[i] = 0;
        else if (!req_valid[i] && c < 2900 && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1;
          req_write[i] = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW] = 8'($urandom_range(1, 5));
          req_wdata[i*LW +: LW] = $urandom();
        end
      end
    end
    chk("drain_valid", req_valid, 0);
    chk("random_activity", (m_nresp - n0) > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
